// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel-PLL supervisor.
package vga_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_pll_supervisor.sv
// Pixel-PLL supervisor: reset pulse, lock qualification,
// bounded retries, fault latch and a registered pixel release.
module vga_pll_supervisor
  import vga_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 3
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               vga_rst_n,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [7:0]         lock_loss_cnt
);

  localparam int RW = cnt_w(RST_CYCLES + 1);
  localparam int SW = cnt_w(STABLE_CYCLES + 1);
  localparam int TW = cnt_w(TIMEOUT_CYCLES + 1);
  localparam int CW = cnt_w(MAX_RETRY + 1);

  localparam logic [RW-1:0] RST_LAST =
    RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST =
    SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_MAX =
    CW'(MAX_RETRY);

  state_t        cur;
  state_t        nxt;
  logic          locked;
  logic [RW-1:0] rst_cnt;
  logic [SW-1:0] stb_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] retry;

  logic cur_lock;
  logic nxt_lock;
  logic timeout;
  logic at_max;
  logic clr_retry;
  logic bump_retry;
  logic loss_inc;

  sync_2ff u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked)
  );

  assign cur_lock = (cur == WAIT_LOCK) || (cur == STABLE);
  assign nxt_lock = (nxt == WAIT_LOCK) || (nxt == STABLE);
  assign timeout  = cur_lock && (tmo_cnt == TMO_LAST);
  assign at_max   = (retry == RETRY_MAX);

  assign clr_retry  = relock_req || (cur == RUN);
  assign bump_retry = !relock_req && timeout && !at_max;
  assign loss_inc   = !relock_req && (cur == RUN) &&
                      !locked && (lock_loss_cnt != 8'hFF);

  // relock_req overrides every other transition
  always_comb begin
    nxt = cur;
    if (relock_req) begin
      nxt = RESET_PLL;
    end else begin
      case (cur)
        RESET_PLL: begin
          if (rst_cnt == RST_LAST) nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (timeout)
            nxt = at_max ? FAULT : RESET_PLL;
          else if (locked)
            nxt = STABLE;
        end
        STABLE: begin
          if (timeout)
            nxt = at_max ? FAULT : RESET_PLL;
          else if (!locked)
            nxt = WAIT_LOCK;
          else if (stb_cnt == STB_LAST)
            nxt = RUN;
        end
        RUN: begin
          if (!locked) nxt = RESET_PLL;
        end
        FAULT:   nxt = FAULT;
        default: nxt = RESET_PLL;
      endcase
    end
  end

  // outputs decoded from nxt so they are registered with the state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= RESET_PLL;
      pll_rst   <= 1'b1;
      vga_rst_n <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur       <= nxt;
      pll_rst   <= (nxt == RESET_PLL) || (nxt == FAULT);
      vga_rst_n <= (nxt == RUN);
      fault     <= (nxt == FAULT);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt <= '0;
      stb_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      rst_cnt <= (cur == RESET_PLL && nxt == RESET_PLL &&
                  !relock_req) ? rst_cnt + 1'b1 : '0;
      stb_cnt <= (cur == STABLE && nxt == STABLE) ?
                 stb_cnt + 1'b1 : '0;
      tmo_cnt <= (cur_lock && nxt_lock) ?
                 tmo_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry <= '0;
    end else begin
      unique case (1'b1)
        clr_retry:  retry <= '0;
        bump_retry: retry <= retry + 1'b1;
        default:    retry <= retry;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_inc) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_vga_pll_supervisor.sv
// Self-checking bench: bring-up vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_vga_pll_supervisor;
  import vga_pkg::*;

  localparam int RSTC = 4;
  localparam int STBC = 8;
  localparam int TMO  = 64;
  localparam int MAXR = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       vga_rst_n;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  vga_pll_supervisor #(
    .RST_CYCLES     (RSTC),
    .STABLE_CYCLES  (STBC),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .vga_rst_n     (vga_rst_n),
    .fault         (fault),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  // behavioural model: time-in-state and attempt age
  state_t m_st = RESET_PLL;
  int     m_age = 0;
  int     m_try = 0;
  int     m_retry = 0;
  int     m_loss = 0;
  bit     m_s1 = 1'b0;
  bit     m_s2 = 1'b0;

  function automatic void model_reset();
    m_st = RESET_PLL;
    m_age = 0;
    m_try = 0;
    m_retry = 0;
    m_loss = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
  endfunction

  function automatic bit in_lock(state_t s);
    return (s == WAIT_LOCK) || (s == STABLE);
  endfunction

  function automatic void model_step(bit rq, bit lk);
    bit     l;
    state_t nx;
    l = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    nx = m_st;
    if (rq) begin
      nx = RESET_PLL;
      m_retry = 0;
    end else if (in_lock(m_st) && m_try == TMO - 1) begin
      if (m_retry == MAXR) nx = FAULT;
      else begin
        m_retry++;
        nx = RESET_PLL;
      end
    end else begin
      case (m_st)
        RESET_PLL: if (m_age == RSTC - 1) nx = WAIT_LOCK;
        WAIT_LOCK: if (l) nx = STABLE;
        STABLE: begin
          if (!l) nx = WAIT_LOCK;
          else if (m_age == STBC - 1) nx = RUN;
        end
        RUN: begin
          if (!l) begin
            nx = RESET_PLL;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
    if (nx == RUN) m_retry = 0;
    if (in_lock(nx) && in_lock(m_st)) m_try++;
    else m_try = 0;
    if (nx == m_st && !rq) m_age++;
    else m_age = 0;
    m_st = nx;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s act=%0d exp=%0d t=%0t",
               phase, name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [13:0] act;
    logic [13:0] exp;
    bit pr;
    bit vg;
    bit ft;
    pr = (m_st == RESET_PLL) || (m_st == FAULT);
    vg = (m_st == RUN);
    ft = (m_st == FAULT);
    act = {state, pll_rst, vga_rst_n, fault, lock_loss_cnt};
    exp = {m_st, pr, vg, ft, m_loss[7:0]};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/model act=%h exp=%h t=%0t",
               phase, act, exp, $time);
    end
  endtask

  task automatic tick(input bit rs, input bit lk, input bit rq);
    rst_n = rs;
    pll_locked = lk;
    relock_req = rq;
    @(posedge refclk);
    if (!rs) model_reset();
    else model_step(rq, lk);
    #1;
    check_model();
  endtask

  task automatic wait_run(input int bound);
    int n;
    n = 0;
    while (state != RUN && n < bound) begin
      tick(1, 1, 0);
      n++;
    end
    check("reach_run", int'(state), int'(RUN));
  endtask

  typedef struct {
    bit     rs;
    bit     lk;
    bit     rq;
    state_t st;
    bit     pr;
    bit     vg;
    bit     ft;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int cnt, input bit rs, input bit lk,
                     input state_t st, input bit pr,
                     input bit vg);
    for (int i = 0; i < cnt; i++)
      tbl.push_back('{rs, lk, 1'b0, st, pr, vg, 1'b0});
  endtask

  initial begin
    int n;
    int wl;
    int pr;
    int lat;
    int max_lat;
    bit saw_wl;
    bit lk;

    add(2, 0, 0, RESET_PLL, 1, 0);
    add(3, 1, 0, RESET_PLL, 1, 0);
    add(10, 1, 0, WAIT_LOCK, 0, 0);
    add(2, 1, 1, WAIT_LOCK, 0, 0);
    add(8, 1, 1, STABLE, 0, 0);
    add(3, 1, 1, RUN, 0, 1);

    phase = "bringup";
    foreach (tbl[i]) begin
      tick(tbl[i].rs, tbl[i].lk, tbl[i].rq);
      check($sformatf("vec%0d", i),
            {state, pll_rst, vga_rst_n, fault},
            {tbl[i].st, tbl[i].pr, tbl[i].vg, tbl[i].ft});
    end
    check("loss_after_reset", lock_loss_cnt, 0);

    phase = "glitch";
    tick(1, 1, 1);
    n = 0;
    while (state != STABLE && n < 20) begin
      tick(1, 1, 0);
      n++;
    end
    check("enter_stable", int'(state), int'(STABLE));
    for (int i = 0; i < 3; i++) tick(1, 1, 0);
    tick(1, 0, 0);
    n = 0;
    saw_wl = 0;
    while (n < 40) begin
      tick(1, 1, 0);
      n++;
      if (state == WAIT_LOCK) saw_wl = 1;
      if (state == RUN) break;
    end
    check("saw_wait_lock", saw_wl, 1);
    check("ticks_to_run", n, 11);

    phase = "relock_vs_loss";
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(1, 1, 1);
    check("relock_state", int'(state), int'(RESET_PLL));
    check("loss_unchanged", lock_loss_cnt, 0);
    wait_run(40);
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    check("loss_one", lock_loss_cnt, 1);
    check("vga_low", vga_rst_n, 0);
    wait_run(40);

    for (int rep = 0; rep < 2; rep++) begin
      phase = $sformatf("timeout%0d", rep);
      tick(1, 0, 1);
      wl = 0;
      pr = 1;
      n = 0;
      while (!fault && n < 400) begin
        tick(1, 0, 0);
        n++;
        if (fault) break;
        if (pll_rst) pr++;
        else wl++;
      end
      check("attempt_cycles", wl, 3 * TMO);
      check("rst_pulse_cycles", pr, 3 * RSTC);
      check("fault_state", int'(state), int'(FAULT));
      for (int i = 0; i < 5; i++) tick(1, 1, 0);
      check("fault_held", {fault, pll_rst, vga_rst_n}, 3'b110);
      tick(1, 0, 1);
      check("fault_cleared", fault, 0);
      check("fault_exit", int'(state), int'(RESET_PLL));
    end
    wait_run(40);

    phase = "saturate";
    max_lat = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1, 0, 0);
      lat = 1;
      while (vga_rst_n && lat < 6) begin
        tick(1, 1, 0);
        lat++;
      end
      if (lat > max_lat) max_lat = lat;
      wait_run(40);
    end
    check("drop_latency_ok", max_lat <= 3, 1);
    check("loss_sat", lock_loss_cnt, 255);

    phase = "random";
    lk = 1;
    for (int i = 0; i < 4000; i++) begin
      n = ((i / 500) % 2 == 0) ? 25 : 90;
      if ($urandom_range(0, n) == 0) lk = ~lk;
      tick($urandom_range(0, 399) != 0, lk,
           $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
